// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer on the 50 MHz reference clock: pulses the PLL reset, waits for a
// stable lock, then releases the system reset; retries on timeout or loss of lock.
module pll_reset_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       clk_50mhz,
  input  logic       reset_N,
  input  logic       pll_locked,
  input  logic       soft_relock,
  output logic       pll_rst,
  output logic       sys_reset_N,
  output logic       lock_lost,
  output logic [3:0] retry_cnt,
  output logic [1:0] ctrl_state
);

  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'b00,
    WAIT_LOCK = 2'b01,
    STABILIZE = 2'b10,
    RUN       = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_s_q, lock_s_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             lock_lost_q, lock_lost_d;
  logic             retry_inc;

  always_ff @(posedge clk_50mhz or negedge reset_N) begin
    if (!reset_N) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // One shared counter: pulse length, lock timeout and stable-lock run all reuse it.
  always_comb begin
    lock_meta_d = pll_locked;
    lock_s_d    = lock_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    lock_lost_d = 1'b0;
    retry_inc   = 1'b0;

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = RESET_PLL;
          cnt_d     = '0;
          retry_inc = 1'b1;
        end
      end
      STABILIZE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = '0;
        // Lock loss wins over a simultaneous soft re-lock request.
        if (!lock_s_q) begin
          state_d     = RESET_PLL;
          lock_lost_d = 1'b1;
          retry_inc   = 1'b1;
        end else if (soft_relock) begin
          state_d = RESET_PLL;
        end
      end
    endcase

    retry_d = (retry_inc && (retry_q != 4'hF)) ? retry_q + 4'd1 : retry_q;

    // Registered from next state so both resets change on the transition edge.
    pll_rst_d   = (state_d == RESET_PLL);
    sys_rst_n_d = (state_d == RUN);
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset_N = sys_rst_n_q;
  assign lock_lost   = lock_lost_q;
  assign retry_cnt   = retry_q;
  assign ctrl_state  = state_q;

endmodule
